vga_pixel_pipe: RTL and testbench
=================================

# vga_pixel_pipe

Downstream consumer of the VGA timing generator. Turns each `(x, y)` position and its raw sync pair into a framebuffer read, a palette lookup and registered 12-bit RGB with delay-matched syncs. The 160x120 indexed-colour framebuffer is double-buffered, with bank swaps applied only at the start of vertical blanking. Outputs drive the VGA DAC pins directly.

## Interface
Parameters:
- `HACTIVE`, 640, active pixels per line
- `VACTIVE`, 480, active lines per frame
- `SCALE_LOG2`, 2, log2 of the pixel replication factor (4x4)
- `FB_W`, 160, framebuffer width (`HACTIVE >> SCALE_LOG2`)
- `FB_H`, 120, framebuffer height (`VACTIVE >> SCALE_LOG2`)
- `PIX_BITS`, 4, palette index width
- `ADDR_W`, 15, framebuffer address width (must satisfy FB_W*FB_H ≤ 2^ADDR_W)

Ports:
- `clk` in 1: pixel clock (same clock as the timing generator).
- `reset` in 1: synchronous, active-high.
- `x` in 10: horizontal count from the timing generator.
- `y` in 10: vertical count from the timing generator.
- `hsync_in` in 1: raw active-low hsync.
- `vsync_in` in 1: raw active-low vsync.
- `fb_raddr` out ADDR_W: framebuffer read address (registered).
- `fb_rbank` out 1: bank being read; always equals `disp_bank`.
- `fb_rdata` in PIX_BITS: synchronous RAM read data, valid one cycle after `fb_raddr`.
- `swap_req` in 1: single-cycle request to swap display bank.
- `swap_busy` out 1: swap pending, not yet applied.
- `disp_bank` out 1: bank currently displayed.
- `hsync`, `vsync` out 1 each: delay-matched active-low syncs.
- `r`, `g`, `b` out 4 each: pixel colour.
- `frame_start` out 1: one-cycle pulse aligned with output pixel (0,0).

## Operation
- Active region: `act0 = (x < HACTIVE) && (y < VACTIVE)`.
- Address: `fb_raddr = (y >> SCALE_LOG2) * FB_W + (x >> SCALE_LOG2)`. Implement as shift-add, (yy<<7)+(yy<<5)+xx for the defaults. Width is ADDR_W with no truncation inside the active region.
- When `act0` = 0, `fb_raddr` is 0. The RAM read still happens, but its data is discarded.
- Palette: fixed 16-entry PIX_BITS→12-bit map from the shared package.
  - Index 0 = 000, 15 = FFF.
  - Indices 1–14 are as listed in the package.
- Output colour is the palette entry when the delayed active flag is 1, else 000. Colour is never driven during blanking.
- Swap controller, two states:
  - **IDLE**: `swap_req` → PENDING; `swap_busy` = 1 from the next cycle.
  - **PENDING**: at the input-side cycle with `x == 0 && y == VACTIVE`, toggle `disp_bank` and return to IDLE. `swap_req` in PENDING is ignored, so there is no double toggle.
  - A `swap_req` in the exact apply cycle while IDLE moves to PENDING and is applied next frame.
  - A `swap_req` in the apply cycle while PENDING is absorbed by the current swap.
- `frame_start` is generated from input `x == 0 && y == 0` and delayed through the pipeline.

## Timing
- Latency is 3 cycles from input `(x, y, hsync_in, vsync_in)` to `r/g/b/hsync/vsync/frame_start`.
  - Cycle t: inputs.
  - t+1: `fb_raddr` registered, together with `act1`, `hs1`, `vs1`, `fs1`.
  - t+2: `fb_rdata` valid; `act2`, `hs2`, `vs2`, `fs2`.
  - t+3: outputs registered.
- Syncs pass through exactly 3 flops each, with no combinational path from input to output.
- A `disp_bank` toggle at the apply cycle is visible on `fb_rbank` the next cycle. This is always inside vertical blanking, so no visible line mixes banks.
- Reset values: `fb_raddr` 0, `disp_bank` 0, `swap_busy` 0, `hsync` 1, `vsync` 1, `r/g/b` 0, `frame_start` 0. All pipeline flags are cleared, so syncs stay deasserted (high) until the pipeline refills.
- Reset mid-frame or mid-PENDING discards the pending swap and returns `disp_bank` to 0. The first valid output appears 3 cycles after reset is released.

## Structure
- Package `vga_pkg`:
  - Timing constants `HACTIVE`/`VACTIVE`, `FB_W`/`FB_H`.
  - `typedef logic [3:0] chan_t`.
  - `typedef struct packed {chan_t r, g, b;} rgb_t`.
  - Palette constant array `PALETTE[16]` of `rgb_t`.
  - Enum `swap_state_t {IDLE, PENDING}`.
- One sub-module, `vga_bank_swap`: the swap FSM. Inputs are `clk`, `reset`, `swap_req` and the apply strobe; outputs are `disp_bank` and `swap_busy`.
- Address generation, the delay line and the palette stay in the top module.

## Test plan
- Reset, then free-run one frame with ideal timing-generator stimulus.
  - `hsync`/`vsync` must equal the inputs delayed by exactly 3 cycles.
  - `frame_start` pulses exactly once per frame.
- x=13, y=9 → `fb_raddr` = 2*160+3 = 323 one cycle later. x=639, y=479 → 19199.
- RAM model returns 0xF at address 323 → `rgb` = FFF 3 cycles after (13,9). The same data at x=700 (blanking) → `rgb` = 000.
- Pulse `swap_req` at y=100.
  - `swap_busy` = 1 next cycle.
  - `disp_bank` toggles one cycle after input (0,480), and `swap_busy` = 0 at the same time.
  - A second pulse while busy → exactly one toggle.
- Pulse `swap_req` in the same cycle as input (0,480) with IDLE → no toggle this frame; toggle at the next (0,480).
- Assert `reset` for one cycle mid-frame with a swap pending.
  - All outputs take their reset values on the next cycle, and `disp_bank` = 0.
  - Valid RGB resumes 3 cycles after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, colour types and the fixed palette for the VGA pixel pipeline.
package vga_pkg;

  localparam int HACTIVE = 640;
  localparam int VACTIVE = 480;
  localparam int FB_W    = 160;
  localparam int FB_H    = 120;

  typedef logic [3:0] chan_t;

  typedef struct packed {
    chan_t r;
    chan_t g;
    chan_t b;
  } rgb_t;

  localparam rgb_t PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  typedef enum logic {IDLE, PENDING} swap_state_t;

endpackage

// File: rtl/vga_bank_swap.sv
// Display-bank swap controller: a request is held until the next apply strobe.
//   state   | meaning
//   IDLE    | no swap outstanding; a request arms PENDING
//   PENDING | swap armed; toggles disp_bank on the apply strobe
module vga_bank_swap
  import vga_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic swap_req,
  input  logic apply,
  output logic disp_bank,
  output logic swap_busy
);

  swap_state_t r_state;
  logic        r_disp_bank;
  logic        r_swap_busy;

  // Requests in PENDING are ignored, so repeated pulses cause a single toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_disp_bank <= 1'b0;
      r_swap_busy <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (swap_req) begin
            r_state     <= PENDING;
            r_swap_busy <= 1'b1;
          end
        end
        PENDING: begin
          if (apply) begin
            r_state     <= IDLE;
            r_disp_bank <= ~r_disp_bank;
            r_swap_busy <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_swap_busy <= 1'b0;
        end
      endcase
    end
  end

  assign disp_bank = r_disp_bank;
  assign swap_busy = r_swap_busy;

endmodule

// File: rtl/vga_pixel_pipe.sv
// Three-stage pixel pipeline: framebuffer address, RAM read, palette lookup,
// with syncs and frame_start delay-matched to the colour outputs.
module vga_pixel_pipe #(
  parameter int HACTIVE    = 640,
  parameter int VACTIVE    = 480,
  parameter int SCALE_LOG2 = 2,
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int PIX_BITS   = 4,
  parameter int ADDR_W     = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                hsync_in,
  input  logic                vsync_in,
  output logic [ADDR_W-1:0]   fb_raddr,
  output logic                fb_rbank,
  input  logic [PIX_BITS-1:0] fb_rdata,
  input  logic                swap_req,
  output logic                swap_busy,
  output logic                disp_bank,
  output logic                hsync,
  output logic                vsync,
  output logic [3:0]          r,
  output logic [3:0]          g,
  output logic [3:0]          b,
  output logic                frame_start
);
  import vga_pkg::*;

  localparam logic [9:0] HACT_L = 10'(HACTIVE);
  localparam logic [9:0] VACT_L = 10'(VACTIVE);

  logic              w_act0;
  logic              w_apply;
  logic              w_fs0;
  logic [ADDR_W-1:0] w_xx;
  logic [ADDR_W-1:0] w_yy;
  logic [ADDR_W-1:0] w_addr;

  assign w_act0  = (x < HACT_L) && (y < VACT_L);
  assign w_apply = (x == 10'd0) && (y == VACT_L);
  assign w_fs0   = (x == 10'd0) && (y == 10'd0);
  assign w_xx    = ADDR_W'(x >> SCALE_LOG2);
  assign w_yy    = ADDR_W'(y >> SCALE_LOG2);

  // 160 = 128 + 32, so the row offset is two shifts and an add.
  generate
    if (FB_W == 160 && FB_H == 120) begin : g_shift_add
      assign w_addr = (w_yy << 7) + (w_yy << 5) + w_xx;
    end else begin : g_mult
      assign w_addr = w_yy * ADDR_W'(FB_W) + w_xx;
    end
  endgenerate

  logic [ADDR_W-1:0] r_raddr;
  logic              r_act1, r_hs1, r_vs1, r_fs1;
  logic              r_act2, r_hs2, r_vs2, r_fs2;
  logic              r_hs3, r_vs3, r_fs3;
  rgb_t              r_rgb;

  // Sync flops reset high so the outputs stay deasserted while the pipe refills.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_raddr <= '0;
      r_act1  <= 1'b0;
      r_hs1   <= 1'b1;
      r_vs1   <= 1'b1;
      r_fs1   <= 1'b0;
      r_act2  <= 1'b0;
      r_hs2   <= 1'b1;
      r_vs2   <= 1'b1;
      r_fs2   <= 1'b0;
      r_hs3   <= 1'b1;
      r_vs3   <= 1'b1;
      r_fs3   <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_raddr <= w_act0 ? w_addr : '0;
      r_act1  <= w_act0;
      r_hs1   <= hsync_in;
      r_vs1   <= vsync_in;
      r_fs1   <= w_fs0;
      r_act2  <= r_act1;
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;
      r_fs2   <= r_fs1;
      r_hs3   <= r_hs2;
      r_vs3   <= r_vs2;
      r_fs3   <= r_fs2;
      r_rgb   <= r_act2 ? PALETTE[fb_rdata] : '0;
    end
  end

  vga_bank_swap u_bank_swap (
    .clk       (clk),
    .reset     (reset),
    .swap_req  (swap_req),
    .apply     (w_apply),
    .disp_bank (disp_bank),
    .swap_busy (swap_busy)
  );

  assign fb_raddr    = r_raddr;
  assign fb_rbank    = disp_bank;
  assign hsync       = r_hs3;
  assign vsync       = r_vs3;
  assign frame_start = r_fs3;
  assign r           = r_rgb.r;
  assign g           = r_rgb.g;
  assign b           = r_rgb.b;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Scoreboard bench for vga_pixel_pipe: a driver walks compressed frames and
// queues expected responses; a negedge monitor pops and compares them.
module tb_vga_pixel_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        swap_req = 1'b0;
  logic [14:0] fb_raddr;
  logic        fb_rbank;
  logic [3:0]  fb_rdata;
  logic        swap_busy, disp_bank, hsync, vsync, frame_start;
  logic [3:0]  r, g, b;

  always #5 clk = ~clk;

  vga_pixel_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .fb_raddr    (fb_raddr),
    .fb_rbank    (fb_rbank),
    .fb_rdata    (fb_rdata),
    .swap_req    (swap_req),
    .swap_busy   (swap_busy),
    .disp_bank   (disp_bank),
    .hsync       (hsync),
    .vsync       (vsync),
    .r           (r),
    .g           (g),
    .b           (b),
    .frame_start (frame_start)
  );

  // Synchronous-read framebuffer model
  logic [3:0] mem [0:32767];
  always @(posedge clk) fb_rdata <= mem[fb_raddr];

  typedef struct {
    int          due;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] rgb;
  } out_t;

  typedef struct {
    int          due;
    logic [14:0] addr;
    logic        bank;
    logic        busy;
  } ctl_t;

  out_t q_out[$];
  ctl_t q_ctl[$];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   fs_seen = 0;
  int   fs_exp = 0;
  int   toggles = 0;
  logic last_bank = 1'b0;
  logic m_bank = 1'b0;
  logic m_pend = 1'b0;

  int XS [14] = '{0, 1, 3, 4, 13, 14, 160, 639, 640, 656, 700, 751, 752, 799};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    while (q_ctl.size() > 0 && q_ctl[0].due <= cyc) begin
      ctl_t c;
      c = q_ctl.pop_front();
      if (c.due < cyc) chk("ctl_late", 32'(c.due), 32'(cyc));
      else begin
        chk("fb_raddr", 32'(fb_raddr), 32'(c.addr));
        chk("fb_rbank", 32'(fb_rbank), 32'(c.bank));
        chk("disp_bank", 32'(disp_bank), 32'(c.bank));
        chk("swap_busy", 32'(swap_busy), 32'(c.busy));
      end
    end
    while (q_out.size() > 0 && q_out[0].due <= cyc) begin
      out_t o;
      o = q_out.pop_front();
      if (o.due < cyc) chk("out_late", 32'(o.due), 32'(cyc));
      else begin
        chk("hsync", 32'(hsync), 32'(o.hs));
        chk("vsync", 32'(vsync), 32'(o.vs));
        chk("frame_start", 32'(frame_start), 32'(o.fs));
        chk("rgb", 32'({r, g, b}), 32'(o.rgb));
      end
    end
    if (frame_start === 1'b1) fs_seen++;
    if (disp_bank !== last_bank) toggles++;
    last_bank = disp_bank;
  end

  task automatic step(input int xi, input int yi, input logic req, input logic rst);
    out_t o;
    ctl_t c;
    int   a;
    logic act;
    @(negedge clk);
    x        = xi[9:0];
    y        = yi[9:0];
    hsync_in = !(xi >= 656 && xi < 752);
    vsync_in = !(yi >= 490 && yi < 492);
    swap_req = req;
    reset    = rst;
    if (rst) begin
      while (q_out.size() > 0 && q_out[$].due > cyc) void'(q_out.pop_back());
      while (q_ctl.size() > 0 && q_ctl[$].due > cyc) void'(q_ctl.pop_back());
      for (int k = 1; k <= 3; k++) begin
        o.due = cyc + k; o.hs = 1'b1; o.vs = 1'b1; o.fs = 1'b0; o.rgb = 12'h000;
        q_out.push_back(o);
      end
      c.due = cyc + 1; c.addr = '0; c.bank = 1'b0; c.busy = 1'b0;
      q_ctl.push_back(c);
      m_bank = 1'b0;
      m_pend = 1'b0;
    end else begin
      act = (xi < 640) && (yi < 480);
      a   = act ? (yi / 4) * 160 + xi / 4 : 0;
      if (m_pend && xi == 0 && yi == 480) begin
        m_bank = !m_bank;
        m_pend = 1'b0;
      end else if (!m_pend && req) begin
        m_pend = 1'b1;
      end
      c.due = cyc + 1; c.addr = a[14:0]; c.bank = m_bank; c.busy = m_pend;
      q_ctl.push_back(c);
      o.due = cyc + 3;
      o.hs  = hsync_in;
      o.vs  = vsync_in;
      o.fs  = (xi == 0 && yi == 0);
      o.rgb = (act && mem[a] == 4'hF) ? 12'hFFF : 12'h000;
      q_out.push_back(o);
      if (o.fs) fs_exp++;
    end
  endtask

  // One frame with a sparse x sweep per line; swap pulses and reset land at x=0.
  task automatic run_frame(input int req1, input int req2, input int rst_y);
    for (int yy = 0; yy < 525; yy++) begin
      for (int i = 0; i < 14; i++) begin
        step(XS[i], yy, (i == 0) && (yy == req1 || yy == req2), (i == 0) && (yy == rst_y));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 4'h0;
    mem[0]     = 4'hF;
    mem[323]   = 4'hF;
    mem[19199] = 4'hF;

    step(0, 0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1);
    run_frame(-1, -1, -1);
    run_frame(100, 200, -1);
    run_frame(480, -1, -1);
    run_frame(-1, -1, -1);
    run_frame(100, -1, 200);
    @(negedge clk);
    swap_req = 1'b0;
    repeat (6) @(negedge clk);

    chk("frame_start_count", 32'(fs_seen), 32'(fs_exp));
    chk("bank_toggles", 32'(toggles), 32'd2);
    chk("out_queue_drained", 32'(q_out.size()), 32'd0);
    chk("ctl_queue_drained", 32'(q_ctl.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
